// File: rtl/data_memory_ctrl.sv
// Clocked data memory with req/ready handshake and fixed two-cycle completion.
// Also exposes a memory-mapped AES key/input/result window and drives the AES core.
module data_memory_ctrl #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int DEPTH    = 256,
    parameter int AES_W    = 128,
    parameter int AES_BASE = 16'hFF00
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [ADDR_W-1:0] result,
    input  logic [DATA_W-1:0] rd2,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              memoryOperationComplete,
    output logic              addrError,
    output logic [AES_W-1:0]  aes_key,
    output logic [AES_W-1:0]  aes_in,
    output logic              aes_start,
    output logic              aes_busy,
    input  logic              aes_done,
    input  logic [AES_W-1:0]  aes_out
);
    localparam int N  = AES_W / DATA_W;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t state_reg, state_next;

    logic              rd_reg, wr_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              ready_reg, cmpl_reg, err_reg, start_reg, busy_reg;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    logic              err_next, start_next, ram_we, key_we, in_we;
    logic              accept;

    logic [DATA_W-1:0] key_words [N];
    logic [DATA_W-1:0] in_words  [N];
    logic [DATA_W-1:0] res_words [N];
    logic [DATA_W-1:0] ram [DEPTH];
    logic [DATA_W-1:0] ram_q;

    logic [31:0]       a32, off32;
    logic              is_ram, is_key, is_in, is_res;
    logic [IW-1:0]     widx;

    // req is honoured only once ready has been raised after reset
    assign accept = (state_reg == IDLE) && ready_reg && req;

    always_comb begin
        a32    = 32'(addr_reg);
        off32  = a32 - 32'(AES_BASE);
        is_ram = a32 < 32'(DEPTH);
        is_key = (a32 >= 32'(AES_BASE)) && (off32 < 32'(N));
        is_in  = (a32 >= 32'(AES_BASE)) && (off32 >= 32'(N)) && (off32 < 32'(2*N));
        is_res = (a32 >= 32'(AES_BASE)) && (off32 >= 32'(2*N)) && (off32 < 32'(3*N));
        if (is_in)
            widx = IW'(off32 - 32'(N));
        else if (is_res)
            widx = IW'(off32 - 32'(2*N));
        else
            widx = IW'(off32);
    end

    always_comb begin
        state_next = state_reg;
        rdata_next = rdata_reg;
        err_next   = err_reg;
        start_next = 1'b0;
        ram_we     = 1'b0;
        key_we     = 1'b0;
        in_we      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept)
                    state_next = ACCESS;
            end
            ACCESS: begin
                state_next = DONE;
                if (rd_reg && wr_reg) begin
                    rdata_next = '0;
                    err_next   = 1'b1;
                end else if (!rd_reg && !wr_reg) begin
                    rdata_next = DATA_W'(addr_reg);
                    err_next   = 1'b0;
                end else if (rd_reg) begin
                    err_next = 1'b0;
                    if (is_ram)
                        rdata_next = ram_q;
                    else if (is_key)
                        rdata_next = key_words[widx];
                    else if (is_in)
                        rdata_next = in_words[widx];
                    else if (is_res)
                        rdata_next = res_words[widx];
                    else begin
                        rdata_next = '0;
                        err_next   = 1'b1;
                    end
                end else begin
                    err_next = 1'b0;
                    if (is_ram)
                        ram_we = 1'b1;
                    else if ((is_key || is_in) && !busy_reg) begin
                        key_we     = is_key;
                        in_we      = is_in;
                        start_next = is_in && (widx == IW'(N-1));
                    end else
                        err_next = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
            ready_reg <= 1'b0;
            cmpl_reg  <= 1'b0;
            err_reg   <= 1'b0;
            start_reg <= 1'b0;
            busy_reg  <= 1'b0;
            rdata_reg <= '0;
            rd_reg    <= 1'b0;
            wr_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            for (int i = 0; i < N; i++) begin
                key_words[i] <= '0;
                in_words[i]  <= '0;
                res_words[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            ready_reg <= (state_next == IDLE);
            cmpl_reg  <= (state_reg == ACCESS);
            start_reg <= start_next;
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
            if (accept) begin
                rd_reg    <= memRead;
                wr_reg    <= memWrite;
                addr_reg  <= result;
                wdata_reg <= rd2;
            end
            if (key_we)
                key_words[widx] <= wdata_reg;
            if (in_we)
                in_words[widx] <= wdata_reg;
            // result capture runs regardless of the access FSM
            if (aes_done) begin
                for (int i = 0; i < N; i++)
                    res_words[i] <= aes_out[i*DATA_W +: DATA_W];
            end
            if (start_next)
                busy_reg <= 1'b1;
            else if (aes_done)
                busy_reg <= 1'b0;
        end
    end

    // RAM is read speculatively in IDLE so the word is ready during ACCESS
    always_ff @(posedge clk) begin
        if (ram_we)
            ram[addr_reg[AW-1:0]] <= wdata_reg;
        ram_q <= ram[result[AW-1:0]];
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_pack
            assign aes_key[gi*DATA_W +: DATA_W] = key_words[gi];
            assign aes_in[gi*DATA_W +: DATA_W]  = in_words[gi];
        end
    endgenerate

    assign ready                   = ready_reg;
    assign rdata                   = rdata_reg;
    assign memoryOperationComplete = cmpl_reg;
    assign addrError               = err_reg;
    assign aes_start               = start_reg;
    assign aes_busy                = busy_reg;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Randomized self-checking bench for data_memory_ctrl against a transaction-level model.
module tb_data_memory_ctrl;
    localparam int N    = 8;
    localparam int BASE = 16'hFF00;

    logic         clk = 1'b0, resetn = 1'b1, req = 1'b0, memRead = 1'b0, memWrite = 1'b0;
    logic [15:0]  result = '0, rd2 = '0;
    logic         aes_done = 1'b0;
    logic [127:0] aes_out = '0;
    logic         ready, memoryOperationComplete, addrError, aes_start, aes_busy;
    logic [15:0]  rdata;
    logic [127:0] aes_key, aes_in;

    data_memory_ctrl dut (
        .clk(clk), .resetn(resetn), .req(req), .memRead(memRead), .memWrite(memWrite),
        .result(result), .rd2(rd2), .ready(ready), .rdata(rdata),
        .memoryOperationComplete(memoryOperationComplete), .addrError(addrError),
        .aes_key(aes_key), .aes_in(aes_in), .aes_start(aes_start), .aes_busy(aes_busy),
        .aes_done(aes_done), .aes_out(aes_out)
    );

    always #5 clk = ~clk;

    logic [15:0] m_mem [256];
    logic [15:0] m_key [N];
    logic [15:0] m_in  [N];
    logic [15:0] m_res [N];
    logic        m_busy, m_err, m_start;
    logic [15:0] m_rdata;
    int checks = 0, failures = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_err = 1'b0; m_start = 1'b0; m_rdata = '0;
        for (int i = 0; i < N; i++) begin
            m_key[i] = '0; m_in[i] = '0; m_res[i] = '0;
        end
    endtask

    // kind: 0 ram, 1 key, 2 in, 3 result, 4 unmapped
    task automatic model_op(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        int kind, idx;
        int ai;
        ai = int'(a);
        idx = 0;
        m_start = 1'b0;
        if (ai < 256) kind = 0;
        else if (ai >= BASE && ai < BASE + 3*N) begin
            kind = 1 + (ai - BASE) / N;
            idx  = (ai - BASE) % N;
        end else kind = 4;
        if (r && w) begin
            m_rdata = '0; m_err = 1'b1;
        end else if (!r && !w) begin
            m_rdata = a; m_err = 1'b0;
        end else if (r) begin
            m_err = (kind == 4);
            case (kind)
                0: m_rdata = m_mem[ai];
                1: m_rdata = m_key[idx];
                2: m_rdata = m_in[idx];
                3: m_rdata = m_res[idx];
                default: m_rdata = '0;
            endcase
        end else begin
            if (kind == 0) begin
                m_mem[ai] = d; m_err = 1'b0;
            end else if ((kind == 1 || kind == 2) && !m_busy) begin
                m_err = 1'b0;
                if (kind == 1) m_key[idx] = d;
                else begin
                    m_in[idx] = d;
                    if (idx == N-1) begin
                        m_start = 1'b1; m_busy = 1'b1;
                    end
                end
            end else m_err = 1'b1;
        end
    endtask

    task automatic check_aes_regs(input string tag);
        logic [127:0] ek, ei;
        for (int i = 0; i < N; i++) begin
            ek[i*16 +: 16] = m_key[i];
            ei[i*16 +: 16] = m_in[i];
        end
        check_eq({tag, "_key"}, aes_key, ek);
        check_eq({tag, "_in"}, aes_in, ei);
        check_eq({tag, "_busy"}, aes_busy, m_busy);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ready"}, ready, 0);
        check_eq({tag, "_rdata"}, rdata, 0);
        check_eq({tag, "_cmpl"}, memoryOperationComplete, 0);
        check_eq({tag, "_err"}, addrError, 0);
        check_eq({tag, "_key"}, aes_key, 0);
        check_eq({tag, "_in"}, aes_in, 0);
        check_eq({tag, "_start"}, aes_start, 0);
        check_eq({tag, "_busy"}, aes_busy, 0);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_ready_wait"}, ready, 1);
    endtask

    // Called at a negedge. done_mid pulses aes_done on the ACCESS->DONE edge.
    task automatic run_op(input string tag, input logic r, input logic w, input logic [15:0] a,
                          input logic [15:0] d, input logic done_mid, input logic [127:0] dout,
                          input logic ign);
        wait_ready(tag);
        req = 1'b1; memRead = r; memWrite = w; result = a; rd2 = d;
        @(negedge clk);
        req = 1'b0;
        check_eq({tag, "_acc_ready"}, ready, 0);
        check_eq({tag, "_acc_cmpl"}, memoryOperationComplete, 0);
        model_op(r, w, a, d);
        if (done_mid) begin
            aes_done = 1'b1; aes_out = dout;
            for (int i = 0; i < N; i++) m_res[i] = dout[i*16 +: 16];
            if (!m_start) m_busy = 1'b0;
        end
        if (ign) begin
            req = 1'b1; memRead = 1'b0; memWrite = 1'b1; result = 16'h0003; rd2 = 16'h5A5A;
        end
        @(negedge clk);
        aes_done = 1'b0; req = 1'b0;
        check_eq({tag, "_cmpl"}, memoryOperationComplete, 1);
        check_eq({tag, "_done_ready"}, ready, 0);
        check_eq({tag, "_rdata"}, rdata, m_rdata);
        check_eq({tag, "_err"}, addrError, m_err);
        check_eq({tag, "_start"}, aes_start, m_start);
        check_aes_regs(tag);
        @(negedge clk);
        check_eq({tag, "_post_cmpl"}, memoryOperationComplete, 0);
        check_eq({tag, "_post_start"}, aes_start, 0);
        check_eq({tag, "_post_ready"}, ready, 1);
        $display("op %s r=%0b w=%0b a=%h d=%h rdata=%h err=%0b", tag, r, w, a, d, rdata, addrError);
    endtask

    task automatic pulse_done(input logic [127:0] v);
        aes_done = 1'b1; aes_out = v;
        @(negedge clk);
        aes_done = 1'b0;
        for (int i = 0; i < N; i++) m_res[i] = v[i*16 +: 16];
        m_busy = 1'b0;
        check_eq("done_busy", aes_busy, 0);
        $display("aes_done out=%h", v);
    endtask

    initial begin
        logic [127:0] rv;
        logic [15:0]  ra, rdv;
        int cat;
        model_reset();
        #2 resetn = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("rst");
        resetn = 1'b1;
        #1 check_eq("rst_ready_low", ready, 0);
        @(negedge clk);
        check_eq("rst_ready_rise", ready, 1);

        // 1: store/load round trip
        run_op("t1_st5", 0, 1, 16'd5, 16'hBEEF, 0, '0, 0);
        run_op("t1_ld5", 1, 0, 16'd5, 16'h0, 0, '0, 0);
        check_eq("t1_beef", rdata, 16'hBEEF);
        // 2: pass-through and illegal op
        run_op("t2_pass", 0, 0, 16'h1234, 16'h0, 0, '0, 0);
        check_eq("t2_pass_val", rdata, 16'h1234);
        run_op("t2_ill", 1, 1, 16'd5, 16'h7777, 0, '0, 0);
        check_eq("t2_ill_err", addrError, 1);
        run_op("t2_ld5", 1, 0, 16'd5, 16'h0, 0, '0, 0);
        // 3: out-of-range and unmapped
        run_op("t3_ld300", 1, 0, 16'd300, 16'h0, 0, '0, 0);
        run_op("t3_stff40", 0, 1, 16'hFF40, 16'h1111, 0, '0, 0);
        run_op("t3_ld5", 1, 0, 16'd5, 16'h0, 0, '0, 0);
        check_eq("t3_beef", rdata, 16'hBEEF);
        // 4: load key and input block, last store starts the core
        for (int i = 0; i < 2*N; i++)
            run_op("t4_aes_st", 0, 1, 16'(BASE + i), 16'(i), 0, '0, 0);
        check_eq("t4_key_lo", aes_key[15:0], 16'h0000);
        check_eq("t4_in_hi", aes_in[127:112], 16'h000F);
        check_eq("t4_busy", aes_busy, 1);
        run_op("t4_key_busy", 0, 1, 16'(BASE + 2), 16'hDEAD, 0, '0, 0);
        check_eq("t4_key_busy_err", addrError, 1);
        // 5: result capture and readback
        pulse_done(128'h00112233445566778899AABBCCDDEEFF);
        run_op("t5_ld_r0", 1, 0, 16'(BASE + 16), 16'h0, 0, '0, 0);
        check_eq("t5_r0", rdata, 16'hEEFF);
        run_op("t5_ld_r7", 1, 0, 16'(BASE + 23), 16'h0, 0, '0, 0);
        check_eq("t5_r7", rdata, 16'h0011);
        run_op("t5_st_res", 0, 1, 16'(BASE + 16), 16'h1234, 0, '0, 0);
        // 6: reset during ACCESS of a store
        run_op("t6_seed7", 0, 1, 16'd7, 16'h0000, 0, '0, 0);
        wait_ready("t6");
        req = 1'b1; memRead = 1'b0; memWrite = 1'b1; result = 16'd7; rd2 = 16'hAAAA;
        @(negedge clk);
        req = 1'b0;
        resetn = 1'b0;
        #1 check_all_zero("t6_rst");
        repeat (2) begin
            @(negedge clk);
            check_eq("t6_no_cmpl", memoryOperationComplete, 0);
        end
        resetn = 1'b1;
        model_reset();
        @(negedge clk);
        run_op("t6_ld7", 1, 0, 16'd7, 16'h0, 0, '0, 0);
        check_eq("t6_not_aaaa", rdata, 16'h0000);

        // random phase: seed a small RAM region, then mixed traffic
        for (int i = 0; i < 16; i++)
            run_op("seed", 0, 1, 16'(i), 16'($urandom), 0, '0, 0);
        for (int it = 0; it < 300; it++) begin
            cat = $urandom_range(0, 9);
            rdv = 16'($urandom);
            rv  = {$urandom, $urandom, $urandom, $urandom};
            case (cat)
                0: run_op("r_pass", 0, 0, 16'($urandom), rdv, 0, '0, 1'($urandom));
                1: run_op("r_ill", 1, 1, 16'($urandom_range(0, 15)), rdv, 0, '0, 0);
                2, 3: run_op("r_st", 0, 1, 16'($urandom_range(0, 15)), rdv, 0, '0, 1'($urandom));
                4: run_op("r_ld", 1, 0, 16'($urandom_range(0, 15)), rdv, 0, '0, 1'($urandom));
                5: begin
                    ra = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(256, 16'hFEFF))
                                                     : 16'($urandom_range(16'hFF18, 16'hFFFF));
                    run_op("r_unmap", 1'($urandom), 1'($urandom), ra, rdv, 0, '0, 0);
                end
                6: run_op("r_aes_st", 0, 1, 16'(BASE + $urandom_range(0, 2*N-1)), rdv, 0, '0, 0);
                7: run_op("r_aes_ld", 1, 0, 16'(BASE + $urandom_range(0, 3*N-1)), rdv,
                          1'($urandom), rv, 0);
                8: pulse_done(rv);
                default: run_op("r_start", 0, 1, 16'(BASE + 2*N - 1), rdv, 0, '0, 0);
            endcase
        end
        // confirm seeded RAM survived the ignored requests
        for (int i = 0; i < 16; i++)
            run_op("final_ld", 1, 0, 16'(i), 16'h0, 0, '0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
